// File: rtl/ps2_pkg.sv
// Shared state encoding and default timing for the PS/2 host-to-device transmitter.
// Timing defaults assume a 100 MHz system clock.
package ps2_pkg;

   localparam int unsigned DEF_CLK_INHIBIT_CYCLES   = 12000;
   localparam int unsigned DEF_START_TIMEOUT_CYCLES = 1500000;
   localparam int unsigned DEF_XFER_TIMEOUT_CYCLES  = 200000;
   localparam int unsigned DEF_FILTER_CYCLES        = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_INHIBIT = 3'd1;
   localparam state_t ST_REQUEST = 3'd2;
   localparam state_t ST_DATA    = 3'd3;
   localparam state_t ST_PARITY  = 3'd4;
   localparam state_t ST_STOP    = 3'd5;
   localparam state_t ST_ACK     = 3'd6;
   localparam state_t ST_RELEASE = 3'd7;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line.
// Emits the accepted level and a one-cycle pulse on each accepted 1->0 transition.
module ps2_line_filter #(
   parameter int unsigned FILTER_CYCLES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   localparam int unsigned CW = $clog2(FILTER_CYCLES) + 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_fall;
   logic [CW-1:0] r_cnt;

   // Idle bus is pulled high, so reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_line;
         r_sync2 <= r_sync1;
         r_fall  <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_fall  <= r_level;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_level = r_level;
   assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, then device ack; open-drain drive on both lines.
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_INHIBIT_CYCLES   = DEF_CLK_INHIBIT_CYCLES,
   parameter int unsigned START_TIMEOUT_CYCLES = DEF_START_TIMEOUT_CYCLES,
   parameter int unsigned XFER_TIMEOUT_CYCLES  = DEF_XFER_TIMEOUT_CYCLES,
   parameter int unsigned FILTER_CYCLES        = DEF_FILTER_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   inout  wire        ps2_clk,
   inout  wire        ps2_data
);

   localparam int unsigned CNT_W =
      $clog2(max3(CLK_INHIBIT_CYCLES, START_TIMEOUT_CYCLES, XFER_TIMEOUT_CYCLES)) + 1;

   state_t             r_state;
   logic [7:0]         r_byte;
   logic               r_parity;
   logic               r_clk_oe;
   logic               r_data_oe;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_edge;
   logic               r_done;
   logic               r_error;

   logic               w_clk_level;
   logic               w_clk_fall;
   logic               w_data_level;
   logic               w_unused_data_fall;
   logic               w_abort;

   ps2_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_clk_filter (
      .clk     (clk),
      .reset   (reset),
      .i_line  (ps2_clk),
      .o_level (w_clk_level),
      .o_fall  (w_clk_fall)
   );

   ps2_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_data_filter (
      .clk     (clk),
      .reset   (reset),
      .i_line  (ps2_data),
      .o_level (w_data_level),
      .o_fall  (w_unused_data_fall)
   );

   always_comb begin
      w_abort = 1'b0;
      case (r_state)
         ST_REQUEST: w_abort = !w_clk_fall && (r_cnt == CNT_W'(START_TIMEOUT_CYCLES));
         ST_DATA, ST_PARITY, ST_STOP: w_abort = (r_cnt == CNT_W'(XFER_TIMEOUT_CYCLES));
         // A released data line at the ack edge is a missing ack.
         ST_ACK: w_abort = (r_cnt == CNT_W'(XFER_TIMEOUT_CYCLES)) || (w_clk_fall && w_data_level);
         default: w_abort = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_byte    <= '0;
         r_parity  <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_cnt     <= '0;
         r_edge    <= '0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         if (w_abort) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (tx_valid && tx_ready) begin
                     r_byte   <= tx_data;
                     r_parity <= ~^tx_data;
                     r_clk_oe <= 1'b1;
                     r_cnt    <= '0;
                     r_edge   <= '0;
                     r_state  <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  if (r_cnt == CNT_W'(CLK_INHIBIT_CYCLES - 1)) begin
                     r_data_oe <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= ST_REQUEST;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_REQUEST: begin
                  r_clk_oe <= 1'b0;
                  if (w_clk_fall) begin
                     r_data_oe <= ~r_byte[0];
                     r_edge    <= 4'd1;
                     r_cnt     <= '0;
                     r_state   <= ST_DATA;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               ST_DATA: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_clk_fall) begin
                     r_data_oe <= ~r_byte[r_edge[2:0]];
                     r_edge    <= r_edge + 4'd1;
                     if (r_edge == 4'd7) r_state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_clk_fall) begin
                     r_data_oe <= ~r_parity;
                     r_edge    <= r_edge + 4'd1;
                     r_state   <= ST_STOP;
                  end
               end
               ST_STOP: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_clk_fall) begin
                     r_data_oe <= 1'b0;
                     r_edge    <= r_edge + 4'd1;
                     r_state   <= ST_ACK;
                  end
               end
               ST_ACK: begin
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_clk_fall) begin
                     r_edge  <= r_edge + 4'd1;
                     r_state <= ST_RELEASE;
                  end
               end
               ST_RELEASE: begin
                  if (w_clk_level && w_data_level) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Hold off ready for the pulse cycle so a lingering tx_valid cannot restart.
   assign tx_ready = (r_state == ST_IDLE) && !r_done && !r_error;
   assign tx_done  = r_done;
   assign tx_error = r_error;

   assign ps2_clk  = r_clk_oe  ? 1'b0 : 1'bz;
   assign ps2_data = r_data_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a behavioural PS/2 device clocks out the host frame,
// and the captured bits and outcome are compared against a frame built from the byte.
module tb_ps2_transmitter;

   localparam int unsigned INH   = 50;
   localparam int unsigned START = 300;
   localparam int unsigned XFER  = 1000;
   localparam int unsigned FILT  = 8;
   localparam int          HPH   = 20;
   localparam int          LPH   = 20;

   localparam int RES_NONE = 0;
   localparam int RES_DONE = 1;
   localparam int RES_ERR  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   wire        ps2_clk;
   wire        ps2_data;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   assign ps2_clk  = dev_clk  ? 1'bz : 1'b0;
   assign ps2_data = dev_data ? 1'bz : 1'b0;
   pullup (ps2_clk);
   pullup (ps2_data);

   ps2_transmitter #(
      .CLK_INHIBIT_CYCLES   (INH),
      .START_TIMEOUT_CYCLES (START),
      .XFER_TIMEOUT_CYCLES  (XFER),
      .FILTER_CYCLES        (FILT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx_error (tx_error),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   // Pulse counters: one increment per cycle the output is high.
   always @(posedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_error === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt++;
   end

   int         obs_inh;
   int         obs_both;
   int         obs_gap;
   int         obs_res;
   logic [9:0] obs_bits;
   logic       obs_rdy0;
   logic       obs_rdy1;
   logic       obs_dl;
   logic       obs_cl;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame as the device sees it, in edge order: 8 data bits LSB first, odd parity, stop.
   function automatic logic [9:0] exp_frame(input logic [7:0] b);
      logic [9:0] f;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[i] = b[i];
         if (b[i]) ones++;
      end
      f[8] = ((ones % 2) == 0);
      f[9] = 1'b1;
      return f;
   endfunction

   task automatic record_result();
      obs_res  = (tx_done === 1'b1) ? RES_DONE : RES_ERR;
      obs_rdy0 = tx_ready;
      obs_dl   = ps2_data;
      obs_cl   = ps2_clk;
   endtask

   // last_e = 0: device never clocks; 1..10: stop with clock held low after that edge.
   task automatic xfer(input logic [7:0] b, input bit ack, input bit hold,
                       input int glitch_e, input int last_e);
      int k;
      obs_res  = RES_NONE;
      obs_bits = '0;
      obs_inh  = 0;
      obs_both = 0;
      obs_gap  = 0;
      obs_rdy0 = 1'bx;
      obs_rdy1 = 1'bx;
      obs_dl   = 1'bx;
      obs_cl   = 1'bx;
      k = 0;
      while (tx_ready !== 1'b1 && k < 100) begin
         tick(1);
         k++;
      end
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      if (!hold) tx_valid = 1'b0;
      while (ps2_clk === 1'b0 && ps2_data === 1'b1 && obs_inh < int'(INH) + 100) begin
         obs_inh++;
         tick(1);
      end
      while (ps2_clk === 1'b0 && ps2_data === 1'b0 && obs_both < 100) begin
         obs_both++;
         tick(1);
      end
      if (last_e == 0) begin
         while (obs_gap < int'(START) + 100) begin
            tick(1);
            obs_gap++;
            if (tx_error === 1'b1 || tx_done === 1'b1) begin
               record_result();
               break;
            end
         end
         tick(1);
         obs_rdy1 = tx_ready;
         return;
      end
      tick(HPH);
      for (int e = 1; e <= 11; e++) begin
         dev_clk = 1'b0;
         if (e == 11) begin
            for (int i = 1; i <= LPH + 100; i++) begin
               tick(1);
               if (i == LPH) begin
                  dev_clk  = 1'b1;
                  dev_data = 1'b1;
               end
               if (tx_done === 1'b1 || tx_error === 1'b1) begin
                  record_result();
                  break;
               end
            end
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            if (hold) tx_valid = 1'b0;
            tick(1);
            obs_rdy1 = tx_ready;
            break;
         end
         tick(LPH);
         obs_bits[e-1] = (ps2_data === 1'b1);
         if (e == last_e) return;
         dev_clk = 1'b1;
         if (e == 10 && ack) dev_data = 1'b0;
         if (e == glitch_e) begin
            tick(5);
            dev_clk = 1'b0;
            tick(5);
            dev_clk = 1'b1;
         end
         tick(HPH);
      end
   endtask

   initial begin
      logic [7:0] b;
      int d0;
      int e0;

      // Reset state
      tick(3);
      chk("rst_clk_line", 32'(ps2_clk), 32'd1);
      chk("rst_data_line", 32'(ps2_data), 32'd1);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_error", 32'(tx_error), 32'd0);
      reset = 1'b1;
      tick(1);
      chk("rst_ready", 32'(tx_ready), 32'd1);

      // 0xED acknowledged
      d0 = done_cnt; e0 = err_cnt;
      xfer(8'hED, 1'b1, 1'b0, 0, 11);
      chk("ed_inhibit_len", 32'(obs_inh), 32'(INH));
      chk("ed_request_overlap", 32'(obs_both), 32'd1);
      chk("ed_frame", 32'(obs_bits), 32'(exp_frame(8'hED)));
      chk("ed_result", 32'(obs_res), 32'(RES_DONE));
      chk("ed_ready_in_pulse", 32'(obs_rdy0), 32'd0);
      chk("ed_ready_after", 32'(obs_rdy1), 32'd1);
      tick(5);
      chk("ed_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("ed_error_pulses", 32'(err_cnt - e0), 32'd0);

      // 0x00: parity bit set
      xfer(8'h00, 1'b1, 1'b0, 0, 11);
      chk("z_frame", 32'(obs_bits), 32'(exp_frame(8'h00)));
      chk("z_result", 32'(obs_res), 32'(RES_DONE));

      // Random bytes
      for (int t = 0; t < 4; t++) begin
         b = 8'($urandom);
         xfer(b, 1'b1, 1'b0, 0, 11);
         chk("rnd_inhibit_len", 32'(obs_inh), 32'(INH));
         chk("rnd_frame", 32'(obs_bits), 32'(exp_frame(b)));
         chk("rnd_result", 32'(obs_res), 32'(RES_DONE));
      end

      // 0xFF with data left high at the ack edge
      d0 = done_cnt; e0 = err_cnt;
      xfer(8'hFF, 1'b0, 1'b0, 0, 11);
      chk("nack_frame", 32'(obs_bits), 32'(exp_frame(8'hFF)));
      chk("nack_result", 32'(obs_res), 32'(RES_ERR));
      chk("nack_data_released", 32'(obs_dl), 32'd1);
      chk("nack_ready_after", 32'(obs_rdy1), 32'd1);
      tick(5);
      chk("nack_clk_released", 32'(ps2_clk), 32'd1);
      chk("nack_error_pulses", 32'(err_cnt - e0), 32'd1);
      chk("nack_done_pulses", 32'(done_cnt - d0), 32'd0);

      // Device never clocks
      xfer(8'h5A, 1'b1, 1'b0, 0, 0);
      chk("start_to_result", 32'(obs_res), 32'(RES_ERR));
      chk("start_to_cycles", 32'(obs_gap), 32'(START));
      chk("start_to_clk", 32'(obs_cl), 32'd1);
      chk("start_to_data", 32'(obs_dl), 32'd1);

      // Reset while bit 3 (edge 4) is being driven low
      d0 = done_cnt; e0 = err_cnt;
      xfer(8'h00, 1'b1, 1'b0, 0, 4);
      chk("abort_bit3_low", 32'(obs_bits[3]), 32'd0);
      reset = 1'b0;
      #1;
      chk("abort_async_data", 32'(ps2_data), 32'd1);
      tick(1);
      dev_clk = 1'b1;
      tick(3);
      chk("abort_clk_released", 32'(ps2_clk), 32'd1);
      reset = 1'b1;
      tick(30);
      chk("abort_ready", 32'(tx_ready), 32'd1);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_no_error", 32'(err_cnt - e0), 32'd0);
      xfer(8'hF4, 1'b1, 1'b0, 0, 11);
      chk("f4_frame", 32'(obs_bits), 32'(exp_frame(8'hF4)));
      chk("f4_result", 32'(obs_res), 32'(RES_DONE));

      // tx_valid held through the transfer
      d0 = done_cnt;
      b = 8'($urandom);
      xfer(b, 1'b1, 1'b1, 0, 11);
      chk("hold_result", 32'(obs_res), 32'(RES_DONE));
      tick(30);
      chk("hold_single_done", 32'(done_cnt - d0), 32'd1);
      chk("hold_no_restart_clk", 32'(ps2_clk), 32'd1);
      chk("hold_idle_ready", 32'(tx_ready), 32'd1);

      // 5-cycle clock glitch after edge 3
      b = 8'($urandom);
      xfer(b, 1'b1, 1'b0, 3, 11);
      chk("glitch_frame", 32'(obs_bits), 32'(exp_frame(b)));
      chk("glitch_result", 32'(obs_res), 32'(RES_DONE));

      tick(5);
      chk("never_done_and_error", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
